// File: rtl/prim_ram_arb_pkg.sv
// Shared constants and types for the two-requester single-port RAM arbiter.
// The optional init sweep is controlled by PRIM_RAM_ARB_INIT_EN in prim_ram_1p_arb.
package prim_ram_arb_pkg;

  localparam int NumReq = 2;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } arb_state_e;

endpackage

// File: rtl/prim_rr_arb2.sv
// Two-way round-robin arbiter: a lone requester wins, a tie goes to the
// requester that was not granted last. The history register lives in the parent.
module prim_rr_arb2
  import prim_ram_arb_pkg::*;
(
  input  logic [NumReq-1:0] req,
  input  logic              last_q,
  output logic [NumReq-1:0] gnt
);

  always_comb begin
    // NOTE: default every combinational output first so no path leaves it unassigned (no latch).
    gnt = '0;
    unique case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last_q ? 2'b01 : 2'b10;
      default: gnt = '0;
    endcase
  end

endmodule

// File: rtl/prim_ram_1p_arb.sv
// Round-robin arbiter and response router in front of one single-port RAM.
// Define PRIM_RAM_ARB_INIT_EN to zero the whole array after reset before granting.
module prim_ram_1p_arb
  import prim_ram_arb_pkg::*;
#(
  parameter int Width           = 32,
  parameter int Depth           = 128,
  parameter int DataBitsPerMask = 1,
  localparam int Aw             = $clog2(Depth)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [NumReq-1:0]       req_i,
  input  logic [NumReq-1:0]       write_i,
  input  logic [NumReq*Aw-1:0]    addr_i,
  input  logic [NumReq*Width-1:0] wdata_i,
  input  logic [NumReq*Width-1:0] wmask_i,
  output logic [NumReq-1:0]       gnt_o,
  output logic [NumReq-1:0]       rvalid_o,
  output logic [Width-1:0]        rdata_o,
  output logic                    ram_req_o,
  output logic                    ram_write_o,
  output logic [Aw-1:0]           ram_addr_o,
  output logic [Width-1:0]        ram_wdata_o,
  output logic [Width-1:0]        ram_wmask_o,
  input  logic                    ram_rvalid_i,
  input  logic [Width-1:0]        ram_rdata_i,
  output logic                    init_done_o
);

  if (Width % DataBitsPerMask != 0) begin : g_mask_check
    $error("Width must be a multiple of DataBitsPerMask");
  end

  logic          run;
  logic          init_active;
  logic [Aw-1:0] init_addr;

`ifdef PRIM_RAM_ARB_INIT_EN
  arb_state_e    state_q, state_d;
  logic [Aw-1:0] init_cnt_q, init_cnt_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    init_active = 1'b0;
    unique case (state_q)
      ST_INIT: begin
        init_active = 1'b1;
        if (init_cnt_q == Aw'(Depth - 1)) begin
          init_cnt_d = '0;
          state_d    = ST_RUN;
        end else begin
          init_cnt_d = init_cnt_q + 1'b1;
        end
      end
      ST_RUN:  init_active = 1'b0;
      default: state_d = ST_INIT;
    endcase
  end

  assign run         = (state_q == ST_RUN);
  assign init_addr   = init_cnt_q;
  assign init_done_o = run;
`else
  assign run         = 1'b1;
  assign init_active = 1'b0;
  assign init_addr   = '0;
  assign init_done_o = 1'b1;
`endif

  logic [NumReq-1:0] gnt;
  logic              last_q;
  logic              tag_vld_q;
  logic              tag_id_q;
  logic              sel;

  prim_rr_arb2 u_arb (
    .req    (req_i & {NumReq{run}}),
    .last_q (last_q),
    .gnt    (gnt)
  );

  assign gnt_o = gnt;

  // Requester 0 drives the RAM fields whenever requester 1 is not granted.
  assign sel = gnt[1];

  always_comb begin
    ram_req_o   = |gnt;
    ram_write_o = write_i[sel];
    ram_addr_o  = addr_i[sel*Aw +: Aw];
    ram_wdata_o = wdata_i[sel*Width +: Width];
    ram_wmask_o = wmask_i[sel*Width +: Width];
    if (init_active) begin
      ram_req_o   = 1'b1;
      ram_write_o = 1'b1;
      ram_addr_o  = init_addr;
      ram_wdata_o = '0;
      ram_wmask_o = '1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_q    <= 1'b1;
      tag_vld_q <= 1'b0;
      tag_id_q  <= 1'b0;
    end else begin
      tag_vld_q <= |gnt;
      if (|gnt) begin
        last_q   <= gnt[1];
        tag_id_q <= gnt[1];
      end
    end
  end

  // Every RAM response, read or write, returns to whoever owned the previous cycle.
  always_comb begin
    rvalid_o           = '0;
    rvalid_o[tag_id_q] = ram_rvalid_i & tag_vld_q;
  end

  assign rdata_o = ram_rdata_i;

endmodule

// File: doc/prim_ram_1p_arb.md
# prim_ram_1p_arb

Two-requester arbiter and sequencer in front of a single-port SRAM (`prim_ram_1p`). It grants at most one access per cycle using round-robin. It routes each read response back to the requester that issued it. Optionally, it zero-initialises the whole array after reset before accepting traffic. It sits between two bus hosts, e.g. instruction and data fetch, and one shared RAM macro.

## Interface

**Parameters**
- `Width`, default 32: data width in bits.
- `Depth`, default 128: number of words. Need not be a power of two.
- `DataBitsPerMask`, default 1: passed through to the RAM. Not used internally.
- `Aw`, localparam `$clog2(Depth)`: address width.

**Ports**
- `clk_i`, input, 1: clock.
- `rst_ni`, input, 1: reset, asynchronous, active-low.
- `req_i`, input, [1:0]: access request per requester; bit 0 is requester 0.
- `write_i`, input, [1:0]: 1 = write, 0 = read, per requester.
- `addr_i`, input, [2*Aw-1:0]: requester n address in slice `[n*Aw +: Aw]`.
- `wdata_i`, input, [2*Width-1:0]: write data, sliced the same way.
- `wmask_i`, input, [2*Width-1:0]: bit write mask, sliced the same way.
- `gnt_o`, output, [1:0]: one-hot or zero. Access accepted this cycle.
- `rvalid_o`, output, [1:0]: response valid for requester n.
- `rdata_o`, output, [Width-1:0]: shared response data, qualified by `rvalid_o`.
- `ram_req_o`, output, 1: RAM request.
- `ram_write_o`, output, 1: RAM write enable.
- `ram_addr_o`, output, [Aw-1:0]: RAM address.
- `ram_wdata_o`, output, [Width-1:0]: RAM write data.
- `ram_wmask_o`, output, [Width-1:0]: RAM write mask.
- `ram_rvalid_i`, input, 1: RAM response valid. It follows `ram_req_o` by one cycle.
- `ram_rdata_i`, input, [Width-1:0]: RAM read data.
- `init_done_o`, output, 1: array ready; arbitration is enabled.

## Operation

**FSM states**
- States are `ST_INIT` and `ST_RUN`.
- The reset state is `ST_INIT` if `PRIM_RAM_ARB_INIT_EN` is defined, otherwise `ST_RUN`.

**`ST_INIT`**
- `gnt_o` = 0.
- Each cycle the block issues a write with `ram_addr_o` = `init_cnt_q`, `ram_wdata_o` = 0 and `ram_wmask_o` = all ones.
- `init_cnt_q` starts at 0 and increments by 1 per cycle.
- At `init_cnt_q == Depth-1` the write is issued, the counter clears to 0, and the next state is `ST_RUN`.
- There is no wrap beyond `Depth-1`.

**`ST_RUN`**
- Arbitration is combinational in the same cycle.
  - One requester active: it is granted.
  - Both active: the requester not equal to `last_q` is granted.
  - `last_q` updates to the granted index on every grant. Its reset value is 1, so requester 0 wins the first tie.
- Muxing: `ram_req_o` = |`gnt_o`. The other `ram_*_o` outputs carry the granted requester's fields. With no grant they carry requester 0's fields and `ram_req_o` = 0.

**Response tagging**
- On each grant, `tag_vld_q` is set to 1 and `tag_id_q` to the granted index. With no grant, `tag_vld_q` is set to 0.
- `rvalid_o[tag_id_q]` = `ram_rvalid_i & tag_vld_q`.
- Writes also return `rvalid`, matching RAM behaviour.
- Responses to `ST_INIT` writes are dropped, because `tag_vld_q` = 0 during `ST_INIT`.

**`rdata_o`**
- `rdata_o` = `ram_rdata_i`, passed through.

**Reset mid-operation**
- Asynchronous reset returns the FSM to the reset state and sets `init_cnt_q` = 0, `tag_vld_q` = 0, `last_q` = 1.
- An in-flight response is discarded.

## Timing

**Reset values of outputs**
- `gnt_o` = 0 in `ST_INIT`. Without the macro, `gnt_o` follows `req_i` from reset.
- `rvalid_o` = 0.
- `ram_req_o` = 1 with the macro (init starts immediately), else `req_i` dependent.
- `init_done_o` = 0 with the macro, 1 without.

**Latency and handshake**
- Request to grant: 0 cycles (combinational).
- Grant to `rvalid_o`: 1 cycle.
- A requester must hold its request fields stable until granted.
- Back-to-back grants every cycle are supported, with full throughput.

**Init duration**
- The init sweep takes exactly `Depth` cycles.
- `init_done_o` rises in the cycle after the last init write. It is registered, equal to (state == `ST_RUN`).

## Configuration

- Macro: `PRIM_RAM_ARB_INIT_EN`.
- Defined: the `ST_INIT` zero sweep is compiled in. No grants are issued until `init_done_o` = 1.
- Undefined: `ST_INIT` and `init_cnt_q` are removed. `init_done_o` is tied to 1 and arbitration is active from reset.

## Structure

**Package `prim_ram_arb_pkg`**
- Constant `NumReq = 2`.
- Enum `arb_state_e` {`ST_INIT`, `ST_RUN`}.

**Sub-module `prim_rr_arb2`**
- Inputs `req[1:0]` and `last_q`; output one-hot `gnt`.
- The update of `last_q` stays in the parent.

## Test plan

1. Init sweep: with `PRIM_RAM_ARB_INIT_EN`, `Depth` = 8, release reset.
   - Required: 8 writes, to addresses 0..7, with wdata 0 and mask 0xFFFFFFFF.
   - Required: `init_done_o` = 1 at cycle 9 and `gnt_o` = 0 throughout.
   - Required: `req_i` = 2'b11 asserted during init gets no grant.
2. Tie round-robin: `req_i` = 2'b11 held for 4 cycles after init.
   - Required: `gnt_o` sequence 01, 10, 01, 10.
3. Single requester: only `req_i[1]` for 3 cycles.
   - Required: `gnt_o` = 10 every cycle.
   - Then `req_i` = 11: required grant 01.
4. Read routing: requester 0 writes 0xDEADBEEF to address 5, then requester 1 reads address 5.
   - Required: `rvalid_o` = 01 one cycle after the write.
   - Required: `rvalid_o` = 10 with `rdata_o` = 0xDEADBEEF one cycle after the read grant.
5. Write mask: requester 1 writes 0x0000FFFF over 0xDEADBEEF with mask 0x0000FFFF, then reads back.
   - Required: readback 0xDEADFFFF.
6. Reset mid-init: assert `rst_ni` = 0 at `init_cnt_q` = 4.
   - Required: the sweep restarts at address 0, and no `rvalid_o` is asserted for the dropped response.
